// File: rtl/rv32i_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rv32i_dmem_responder
//  Purpose  : Memory-stage data-memory target for an RV32I pipeline.
//             - Holds a word array of 2^DEPTH_LOG2 entries.
//             - Accepts byte-enabled writes (lane-shifted by the requester).
//             - Returns each read one cycle later as:
//                 * the raw registered word, and
//                 * a lane-aligned, sign/zero-extended load value for writeback.
//
//  Ports    :
//    clk          in   1   system clock, rising edge active
//    reset        in   1   asynchronous, active-low reset
//    memif_we     in   1   write request
//    memif_re     in   1   read (load) request
//    memif_be     in   4   byte-lane write enables, bit i -> wdata[8i+7:8i]
//    memif_addr   in  30   word address (byte address bits [31:2])
//    memif_wdata  in  32   write data, already lane-shifted
//    ld_width     in   2   00 byte, 01 half, 10 word, 11 reserved
//    ld_unsigned  in   1   1 selects zero-extension
//    ld_bank      in   2   byte offset inside the word
//    memif_rdata  out 32   raw registered word
//    ld_data      out 32   aligned and extended load value
//    rvalid       out  1   one-cycle pulse: read results are valid
//    addr_err     out  1   returned read was out of range or misaligned
//
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_dmem_responder #(
   parameter int DEPTH_LOG2 = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memif_we,
   input  logic        memif_re,
   input  logic [3:0]  memif_be,
   input  logic [29:0] memif_addr,
   input  logic [31:0] memif_wdata,
   input  logic [1:0]  ld_width,
   input  logic        ld_unsigned,
   input  logic [1:0]  ld_bank,
   output logic [31:0] memif_rdata,
   output logic [31:0] ld_data,
   output logic        rvalid,
   output logic        addr_err
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int         c_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [1:0] c_W_BYTE  = 2'b00;
   localparam logic [1:0] c_W_HALF  = 2'b01;
   localparam logic [1:0] c_W_WORD  = 2'b10;

   // ------------------------------------------------------------------------
   // Storage. Intentionally not reset: contents are undefined at power-up,
   // which lets the array map onto plain RAM macros.
   // ------------------------------------------------------------------------
   logic [31:0] mem [0:c_DEPTH-1];

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic                  w_in_range;
   logic [DEPTH_LOG2-1:0] w_idx;

   assign w_idx = memif_addr[DEPTH_LOG2-1:0];

   // When the array spans the whole 30-bit word space there are no upper
   // address bits left to check, so every address is in range.
   generate
      if (DEPTH_LOG2 >= 30) begin : g_full_range
         assign w_in_range = 1'b1;
      end else begin : g_range_chk
         assign w_in_range = (memif_addr[29:DEPTH_LOG2] == '0);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Write port. Reset gates the enable combinationally so that no write can
   // land while reset is held low, yet the first edge after release is
   // already usable.
   // ------------------------------------------------------------------------
   logic w_wr_en;

   assign w_wr_en = reset & memif_we & w_in_range;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (memif_be[i]) begin
               mem[w_idx][8*i +: 8] <= memif_wdata[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read capture. The array is sampled with a non-blocking update in the
   // same edge as any write, so a colliding read sees the pre-write word
   // (read-first). Result registers only move on a read, so they hold their
   // last value while rvalid is low.
   // ------------------------------------------------------------------------
   logic        rvalid_q,   rvalid_d;
   logic [31:0] rdata_q,    rdata_d;
   logic [1:0]  width_q,    width_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  bank_q,     bank_d;
   logic        oor_q,      oor_d;

   always_comb begin
      rvalid_d   = memif_re;
      rdata_d    = rdata_q;
      width_d    = width_q;
      unsigned_d = unsigned_q;
      bank_d     = bank_q;
      oor_d      = oor_q;
      if (memif_re) begin
         // Out-of-range reads return zero on both data outputs.
         rdata_d    = w_in_range ? mem[w_idx] : 32'h0;
         width_d    = ld_width;
         unsigned_d = ld_unsigned;
         bank_d     = ld_bank;
         oor_d      = ~w_in_range;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'h0;
         width_q    <= c_W_BYTE;
         unsigned_q <= 1'b0;
         bank_q     <= 2'b00;
         oor_q      <= 1'b0;
      end else begin
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         width_q    <= width_d;
         unsigned_q <= unsigned_d;
         bank_q     <= bank_d;
         oor_q      <= oor_d;
      end
   end

   // ------------------------------------------------------------------------
   // Load formatting, driven purely from the registered controls so the
   // formatter sits after the output flops. With everything cleared by reset
   // (byte width, zero word, no error) ld_data is also zero during reset.
   // ------------------------------------------------------------------------
   logic        w_misalign;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_fmt;

   always_comb begin
      w_misalign = 1'b0;
      case (width_q)
         c_W_BYTE: w_misalign = 1'b0;
         c_W_HALF: w_misalign = bank_q[0];
         c_W_WORD: w_misalign = (bank_q != 2'b00);
         default:  w_misalign = 1'b1;   // reserved width
      endcase
   end

   always_comb begin
      w_byte = rdata_q[8*bank_q +: 8];
      // Only banks 00 and 10 are legal for halves; bank[1] picks the half.
      w_half = bank_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      w_fmt  = rdata_q;
      case (width_q)
         c_W_BYTE: w_fmt = {{24{w_byte[7]  & ~unsigned_q}}, w_byte};
         c_W_HALF: w_fmt = {{16{w_half[15] & ~unsigned_q}}, w_half};
         default:  w_fmt = rdata_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign rvalid      = rvalid_q;
   assign memif_rdata = rdata_q;
   assign addr_err    = oor_q | w_misalign;
   assign ld_data     = (oor_q | w_misalign) ? 32'h0 : w_fmt;

endmodule
`default_nettype wire

// File: doc/rv32i_dmem_responder.md
# rv32i_dmem_responder

Data-memory responder on the far end of the memory-stage interface. It accepts word-addressed, byte-enabled write and read requests (`memif_*`) and holds them in an internal word array. It returns each read one cycle later as the raw word and as a load value that is lane-aligned and sign- or zero-extended. It replaces the bare dual-port RAM as the memory-stage target and adds the load formatting step that the writeback stage consumes.

## Interface
Parameters:
- `DEPTH_LOG2`, default 14: number of word-address bits implemented, giving 2^14 words (64 KiB).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memif_we`  in  1  write request.
- `memif_re`  in  1  read (load) request.
- `memif_be`  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
- `memif_addr`  in  30  word address, byte address bits [31:2].
- `memif_wdata`  in  32  write data, already lane-shifted by the requester.
- `ld_width`  in  2  load width (iw[13:12]): 00 byte, 01 half, 10 word, 11 reserved.
- `ld_unsigned`  in  1  iw[14]; 1 selects zero-extend.
- `ld_bank`  in  2  byte offset, alu[1:0].
- `memif_rdata`  out  32  raw registered word.
- `ld_data`  out  32  aligned and extended load value.
- `rvalid`  out  1  one-cycle pulse: `memif_rdata`, `ld_data` and `addr_err` are valid.
- `addr_err`  out  1  the returned read was out of range or misaligned.

## Operation
- **Range check:**
  - Word address is in range iff `memif_addr[29:DEPTH_LOG2]` == 0.
  - Out-of-range writes are dropped.
  - Out-of-range reads return 0 on both data outputs, with `addr_err`=1.
- **Write:** when `memif_we`=1 and the address is in range, each byte lane with `be[i]`=1 is updated on the edge. `be`=0000 is a legal no-op. Any `be` pattern is accepted.
- **Read:** when `memif_re`=1, the edge captures `mem[addr]`, `ld_width`, `ld_unsigned`, `ld_bank` and the error status into output registers.
- **Misaligned load:** half with `bank[0]`=1, word with `bank`≠00, or `ld_width`=11.
  - `rvalid`=1, `addr_err`=1, `ld_data`=0.
  - `memif_rdata` still carries the raw word.
- **Load formatting (from registered controls):**
  - Byte: byte `bank` of the word, sign-extended from bit 7 unless `ld_unsigned`.
  - Half: bank 00 selects [15:0], bank 10 selects [31:16]; sign-extended from bit 15 unless `ld_unsigned`.
  - Word: passthrough; `ld_unsigned` is ignored.
- **Read-during-write:**
  - `we` and `re` may both be asserted in the same cycle.
  - Same address: read-first, so the read returns the pre-write word.
  - The write is still committed.
- **Array contents:** the array is not reset; its contents are undefined after power-up.

## Timing
- Read latency is 1 cycle: a request sampled on edge N gives `rvalid`=1 and valid data from edge N to edge N+1.
- `rvalid` deasserts on the next edge unless a new read is sampled. Back-to-back reads give one result per cycle.
- There is no backpressure; the requester must consume the result in its valid cycle.
- `memif_rdata`, `ld_data` and `addr_err` hold their last values while `rvalid`=0.
- Writes take effect on edge N and are visible to a read sampled on edge N+1.
- Reset asserted (`reset`=0):
  - Immediately and asynchronously: `rvalid`=0, `addr_err`=0, `memif_rdata`=0, `ld_data`=0.
  - A read in flight is discarded and no `rvalid` pulse is produced for it.
  - Writes are blocked while `reset`=0.
- Reset release: the first request can be sampled on the first rising edge after `reset` rises.

## Test plan
1. **Full and partial write, byte loads.** Write 0xDEADBEEF to word 0x10 with `be`=1111, then 0x00007F00 with `be`=0010.
   - Raw read of 0x10 → 0xDEAD7FEF.
   - Byte load, bank 1, signed → 0x0000007F.
   - Byte load, bank 3, signed → 0xFFFFFFDE.
2. **Half loads of word 0x10.**
   - Bank 10, unsigned → 0x0000DEAD.
   - Bank 10, signed → 0xFFFFDEAD.
   - Bank 00, signed → 0x00007FEF.
3. **Read-first collision.** Same cycle: `we` of 0x12345678 and `re` to word 0x10.
   - That cycle's read returns 0xDEAD7FEF.
   - The next read returns 0x12345678.
4. **Errors** (`DEPTH_LOG2`=14):
   - Write to word 0x4000 → array unchanged.
   - Read of word 0x4000 → `rvalid`=1, `addr_err`=1, data 0.
   - Word load with bank 01 → `addr_err`=1, `ld_data`=0.
5. **Back-to-back reads** of words 0–3 on consecutive cycles → four consecutive `rvalid` pulses, each with the data in request order.
6. **Reset mid-read.** Sample a read, then drop `reset` before the next edge.
   - Outputs go to 0 immediately and no `rvalid` pulse appears.
   - After release, a read of 0x10 returns the pre-reset value.
